// File: rtl/alu_sevenseg_pkg.sv
// Shared opcodes and the hex 7-segment glyph table for the ALU display block.
package alu_sevenseg_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Active-high {a,b,c,d,e,f,g} patterns, seg[6] = a; C and E kept distinct
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Nibble to active-high segment pattern
  function automatic logic [SEG_W-1:0] hex_seg(input logic [NIB_W-1:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational nibble to active-high 7-segment decoder; polarity is applied by the caller.
module hex_to_sevenseg
  import alu_sevenseg_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup of the glyph for one hex digit
  always_comb begin
    seg_c = hex_seg(nib);
  end

endmodule

// File: rtl/alu_sevenseg_scan.sv
// Registered ALU whose held result is scanned, one nibble per digit, onto a
// multiplexed hex 7-segment display.
module alu_sevenseg_scan
  import alu_sevenseg_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  localparam int unsigned NDIG          = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       opcode,
  input  logic             en,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             result_valid,
  output logic [6:0]       seg,
  output logic [NDIG-1:0]  an
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [SEG_W-1:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NDIG-1:0]  AN_OFF   = {NDIG{SEG_ACTIVE_LOW}};

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             rv_q, rv_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [NDIG-1:0]  an_q, an_d;

  logic [WIDTH:0]   alu_wide_c;
  logic [NIB_W-1:0] nib_c;
  logic [SEG_W-1:0] seg_ah_c;
  logic [NDIG-1:0]  an_ah_c;

  // ALU: one extra bit so add carry-out and sub borrow fall out of bit WIDTH
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    rv_d     = 1'b0;
    case (opcode)
      OP_ADD:  alu_wide_c = {1'b0, A} + {1'b0, B};
      OP_SUB:  alu_wide_c = {1'b0, A} - {1'b0, B};
      OP_OR:   alu_wide_c = {1'b0, A | B};
      default: alu_wide_c = {1'b0, A ^ B};
    endcase
    if (in_valid) begin
      result_d = alu_wide_c[WIDTH-1:0];
      carry_d  = alu_wide_c[WIDTH];
      zero_d   = (alu_wide_c[WIDTH-1:0] == '0);
      rv_d     = 1'b1;
    end
  end

  // Free-running prescaler and digit index; independent of en
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Select the nibble and digit enable for the current index
  always_comb begin
    nib_c   = '0;
    an_ah_c = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_c      = result_q[4*i +: 4];
        an_ah_c[i] = en;
      end
    end
  end

  hex_to_sevenseg u_hex (
    .nib   (nib_c),
    .seg_c (seg_ah_c)
  );

  // Blanking and pin polarity ahead of the output registers
  always_comb begin
    seg_d = en ? seg_ah_c : '0;
    an_d  = an_ah_c;
    if (SEG_ACTIVE_LOW) begin
      seg_d = ~seg_d;
      an_d  = ~an_d;
    end
  end

  // State and output registers; seg and an share an edge so digits never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      rv_q     <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      rv_q     <= rv_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign result       = result_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign result_valid = rv_q;
  assign seg          = seg_q;
  assign an           = an_q;

endmodule
